// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared sparse state encodings for the AES S-box DOM pipeline controller
//
// Purpose: holds the state width, the sparse state enum and a small legality
// helper used by aes_sbox_dom_ctrl.
// Encodings are 6-bit with pairwise Hamming distance >= 3, so a single or double
// bit upset can never turn one legal state into another. All-zero is
// deliberately not a legal encoding.
package aes_pkg;

  localparam int unsigned StateWidth = 6;

  typedef enum logic [StateWidth-1:0] {
    IDLE     = 6'b100110,
    WAIT_PRD = 6'b011010,
    BUSY     = 6'b110001,
    DONE     = 6'b001101,
    ERROR    = 6'b010100
  } sbox_ctrl_state_e;

  // True for the operational states that clear_i is allowed to abort.
  // ERROR and any illegal encoding return 0.
  function automatic logic state_is_live(sbox_ctrl_state_e s);
    return s inside {IDLE, WAIT_PRD, BUSY, DONE};
  endfunction

endpackage

// File: rtl/prim_sparse_fsm_flop.sv
// rtl/prim_sparse_fsm_flop.sv - state register for sparsely encoded FSMs
//
// Purpose: the single flop bank holding a sparse FSM state, with an explicit
// reset encoding.
// Ports:
//   clk_i    in   clock, rising edge
//   rst_ni   in   asynchronous active-low reset, loads ResetValue
//   state_i  in   next state
//   state_o  out  current state
module prim_sparse_fsm_flop #(
  parameter int unsigned      Width      = 6,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] state_i,
  output logic [Width-1:0] state_o
);

  logic [Width-1:0] state_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ResetValue;
    end else begin
      state_q <= state_i;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/aes_sbox_dom_ctrl.sv
// rtl/aes_sbox_dom_ctrl.sv - hardened control FSM for a DOM-masked AES S-box pipeline
//
// Purpose: sequences one S-box evaluation: waits for fresh randomness, enables
// the pipeline for Latency cycles, then pulses ack_o. Illegal state encodings
// lock the FSM in ERROR with alert_o high until reset.
// Optional feature macro: AES_SBOX_CTRL_CNT_CHECK_EN adds a redundant
// down-counter whose sum with the stage counter is checked every BUSY cycle.
// Ports:
//   clk_i      in   clock, rising edge
//   rst_ni     in   asynchronous active-low reset
//   req_i      in   start request, held by requester until ack_o
//   clear_i    in   synchronous abort (ignored in ERROR)
//   prd_ack_i  in   fresh-randomness grant
//   prd_req_o  out  fresh-randomness request (WAIT_PRD)
//   pipe_en_o  out  S-box pipeline register enable (BUSY)
//   stage_o    out  current pipeline stage, 0 outside BUSY
//   ack_o      out  one-cycle completion pulse (DONE)
//   alert_o    out  fatal FSM/counter fault (ERROR)
// All outputs decode from state/counter only; there is no input-to-output path.
module aes_sbox_dom_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned Latency    = 5,
  parameter int unsigned StateWidth = aes_pkg::StateWidth
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       req_i,
  input  logic       clear_i,
  input  logic       prd_ack_i,
  output logic       prd_req_o,
  output logic       pipe_en_o,
  output logic [2:0] stage_o,
  output logic       ack_o,
  output logic       alert_o
);

  localparam logic [2:0] LastCnt = 3'(Latency - 1);
  localparam logic [2:0] CntMax  = 3'd7;

  logic [StateWidth-1:0] state_raw_q;
  sbox_ctrl_state_e      state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;

  prim_sparse_fsm_flop #(
    .Width      (StateWidth),
    .ResetValue (IDLE)
  ) u_state_regs (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .state_i (state_d),
    .state_o (state_raw_q)
  );

  assign state_q = sbox_ctrl_state_e'(state_raw_q);

`ifdef AES_SBOX_CTRL_CNT_CHECK_EN
  logic [2:0] down_cnt_q, down_cnt_d;
  logic       cnt_mismatch;

  // Both counters move in lockstep, so their sum is constant during BUSY.
  assign cnt_mismatch = ({1'b0, cnt_q} + {1'b0, down_cnt_q}) != {1'b0, LastCnt};
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef AES_SBOX_CTRL_CNT_CHECK_EN
    down_cnt_d = down_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req_i) state_d = WAIT_PRD;
      end
      WAIT_PRD: begin
        if (prd_ack_i) begin
          state_d = BUSY;
          cnt_d   = '0;
`ifdef AES_SBOX_CTRL_CNT_CHECK_EN
          down_cnt_d = LastCnt;
`endif
        end
      end
      BUSY: begin
        if (cnt_q == LastCnt) begin
          state_d = DONE;
        end else if (cnt_q != CntMax) begin
          // Saturating increment: a corrupted counter must never wrap to a
          // stage index that looks legitimate.
          cnt_d = cnt_q + 3'd1;
        end
`ifdef AES_SBOX_CTRL_CNT_CHECK_EN
        if (down_cnt_q != 3'd0) down_cnt_d = down_cnt_q - 3'd1;
`endif
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      ERROR: begin
        state_d = ERROR;
        cnt_d   = '0;
      end
      default: begin
        state_d = ERROR;
        cnt_d   = '0;
      end
    endcase

    // Abort overrides a simultaneous grant or terminal count.
    if (clear_i && state_is_live(state_q)) begin
      state_d = IDLE;
      cnt_d   = '0;
`ifdef AES_SBOX_CTRL_CNT_CHECK_EN
      down_cnt_d = '0;
`endif
    end

`ifdef AES_SBOX_CTRL_CNT_CHECK_EN
    // A counter fault is fatal even if an abort arrives in the same cycle.
    if ((state_q == BUSY) && cnt_mismatch) state_d = ERROR;
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

`ifdef AES_SBOX_CTRL_CNT_CHECK_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      down_cnt_q <= '0;
    end else begin
      down_cnt_q <= down_cnt_d;
    end
  end
`endif

  assign prd_req_o = (state_q == WAIT_PRD);
  assign pipe_en_o = (state_q == BUSY);
  assign stage_o   = (state_q == BUSY) ? cnt_q : 3'd0;
  assign ack_o     = (state_q == DONE);
  assign alert_o   = (state_q == ERROR);

endmodule

// File: tb/tb_aes_sbox_dom_ctrl.sv
// tb/tb_aes_sbox_dom_ctrl.sv - self-checking bench for aes_sbox_dom_ctrl
module tb_aes_sbox_dom_ctrl;

  localparam int Latency = 5;

  logic       clk_i     = 1'b0;
  logic       rst_ni    = 1'b1;
  logic       req_i     = 1'b0;
  logic       clear_i   = 1'b0;
  logic       prd_ack_i = 1'b0;
  logic       prd_req_o;
  logic       pipe_en_o;
  logic [2:0] stage_o;
  logic       ack_o;
  logic       alert_o;

  aes_sbox_dom_ctrl #(
    .Latency    (Latency),
    .StateWidth (6)
  ) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     (req_i),
    .clear_i   (clear_i),
    .prd_ack_i (prd_ack_i),
    .prd_req_o (prd_req_o),
    .pipe_en_o (pipe_en_o),
    .stage_o   (stage_o),
    .ack_o     (ack_o),
    .alert_o   (alert_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic       prd_req;
    logic       pipe_en;
    logic [2:0] stage;
    logic       ack;
    logic       alert;
  } obs_t;

  obs_t exp_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  function automatic obs_t mk(logic p, logic e, logic [2:0] s, logic a, logic al);
    obs_t o;
    o.prd_req = p;
    o.pipe_en = e;
    o.stage   = s;
    o.ack     = a;
    o.alert   = al;
    return o;
  endfunction

  function automatic obs_t observe();
    return mk(prd_req_o, pipe_en_o, stage_o, ack_o, alert_o);
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  // Expected trace of one full transaction: n_prd cycles waiting for the grant,
  // Latency BUSY cycles, the ack pulse, then one idle cycle.
  task automatic push_txn(input int n_prd);
    for (int i = 0; i < n_prd; i++) exp_q.push_back(mk(1'b1, 1'b0, 3'd0, 1'b0, 1'b0));
    for (int i = 0; i < Latency; i++) exp_q.push_back(mk(1'b0, 1'b1, 3'(i), 1'b0, 1'b0));
    exp_q.push_back(mk(1'b0, 1'b0, 3'd0, 1'b1, 1'b0));
    exp_q.push_back(mk(1'b0, 1'b0, 3'd0, 1'b0, 1'b0));
  endtask

  // Compares one queued expectation per cycle, starting at cycle 1 after the
  // request; inputs for the next edge are driven after each comparison.
  task automatic drain(input string tag, input int n_prd, input int req_drop, input int clear_at);
    obs_t e;
    int   n;
    n = 1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check($sformatf("%s_c%0d", tag, n), {1'b0, observe()}, {1'b0, e});
      req_i     = (n < req_drop);
      prd_ack_i = (n >= n_prd);
      clear_i   = (n == clear_at);
      step();
      n++;
    end
    clear_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int acks;

    // Reset state
    #1 rst_ni = 1'b0;
    #1 check("reset_outputs", {1'b0, observe()}, 8'h00);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    step();

    // Nominal latency, grant already high
    prd_ack_i = 1'b1;
    req_i     = 1'b1;
    push_txn(1);
    step();
    drain("latency", 1, 7, -1);

    // Grant delayed 10 cycles, request dropped while waiting
    prd_ack_i = 1'b0;
    req_i     = 1'b1;
    push_txn(11);
    step();
    drain("prd_delay", 11, 3, -1);

    // Abort at the third BUSY cycle
    prd_ack_i = 1'b1;
    req_i     = 1'b1;
    exp_q.push_back(mk(1'b1, 1'b0, 3'd0, 1'b0, 1'b0));
    exp_q.push_back(mk(1'b0, 1'b1, 3'd0, 1'b0, 1'b0));
    exp_q.push_back(mk(1'b0, 1'b1, 3'd1, 1'b0, 1'b0));
    exp_q.push_back(mk(1'b0, 1'b1, 3'd2, 1'b0, 1'b0));
    exp_q.push_back(mk(1'b0, 1'b0, 3'd0, 1'b0, 1'b0));
    exp_q.push_back(mk(1'b0, 1'b0, 3'd0, 1'b0, 1'b0));
    step();
    drain("clear", 1, 2, 4);

    req_i = 1'b1;
    push_txn(1);
    step();
    drain("after_clear", 1, 7, -1);

    // Reset during BUSY stage 2
    prd_ack_i = 1'b1;
    req_i     = 1'b1;
    step();
    step();
    step();
    step();
    check("rst_pre_stage", {1'b0, observe()}, {1'b0, mk(1'b0, 1'b1, 3'd2, 1'b0, 1'b0)});
    rst_ni = 1'b0;
    #1 check("rst_async", {1'b0, observe()}, 8'h00);
    req_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("rst_idle_%0d", i), {1'b0, observe()}, 8'h00);
    end

    // Illegal state encoding locks into ERROR
    force dut.u_state_regs.state_q = 6'b000000;
    step();
    release dut.u_state_regs.state_q;
    step();
    check("illegal_alert", {1'b0, observe()}, {1'b0, mk(1'b0, 1'b0, 3'd0, 1'b0, 1'b1)});
    clear_i   = 1'b1;
    req_i     = 1'b1;
    prd_ack_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("error_hold_%0d", i), {1'b0, observe()}, {1'b0, mk(1'b0, 1'b0, 3'd0, 1'b0, 1'b1)});
    end
    rst_ni = 1'b0;
    #1 check("error_reset", {1'b0, observe()}, 8'h00);
    clear_i = 1'b0;
    req_i   = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    step();

    // Counter fault injection at BUSY stage 1
    prd_ack_i = 1'b1;
    req_i     = 1'b1;
    step();
    step();
    step();
    check("fault_pre_stage", {1'b0, observe()}, {1'b0, mk(1'b0, 1'b1, 3'd1, 1'b0, 1'b0)});
`ifdef AES_SBOX_CTRL_CNT_CHECK_EN
    force dut.down_cnt_q = 3'd2;
    step();
    release dut.down_cnt_q;
    req_i = 1'b0;
    check("dcnt_alert", {1'b0, observe()}, {1'b0, mk(1'b0, 1'b0, 3'd0, 1'b0, 1'b1)});
    rst_ni = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    step();
`else
    force dut.cnt_q = 3'd0;
    step();
    release dut.cnt_q;
    acks = 0;
    for (int i = 0; i < 12; i++) begin
      check($sformatf("cnt_fault_no_alert_%0d", i), {7'd0, alert_o}, 8'h00);
      if (ack_o) begin
        acks++;
        req_i = 1'b0;
      end
      step();
    end
    check("cnt_fault_ack_count", 8'(acks), 8'd1);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
